// File: rtl/cpu_core_pkg.sv
// Shared definitions for the multi-cycle scalar core: opcodes, field slices, FSM states.
package cpu_core_pkg;

  localparam logic [31:0] BOOT_ADDR = 32'h0000_1000;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam int LINE_BITS = 128;

  localparam logic [5:0] OP_LDI  = 6'h01;
  localparam logic [5:0] OP_ADD  = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_MUL  = 6'h04;
  localparam logic [5:0] OP_STOP = 6'h3F;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    EXEC       = 2'd2,
    HALT       = 2'd3
  } state_t;

  function automatic logic [5:0] op_of(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [19:0] imm_of(input logic [31:0] ir);
    return ir[19:0];
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] pc);
    return {pc[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/cpu_core_unit_if.sv
// Memory bus between the core and the line memory: request channel with ready, response channel without.
interface mem_core_bus_request_if;
  logic        valid;
  logic [31:0] addr;
  logic        write;
  logic        ready;

  modport master (output valid, output addr, output write, input ready);
  modport slave  (input valid, input addr, input write, output ready);
endinterface

interface mem_core_bus_response_if;
  logic                               valid;
  logic [cpu_core_pkg::LINE_BITS-1:0] data;

  modport master (output valid, output data);
  modport slave  (input valid, input data);
endinterface

// File: rtl/cpu_reg_bank.sv
// Register file: two combinational read ports, one synchronous write port, cleared on reset.
module cpu_reg_bank
  import cpu_core_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] reg_file [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
    end else if (wr_en) begin
      reg_file[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = reg_file[rs1_addr];
  assign rs2_data = reg_file[rs2_addr];

endmodule

// File: rtl/cpu_core_unit.sv
// Multi-cycle core: fetch line, pick word, execute LDI/ADD/SUB/MUL/STOP, halt with sticky offload.
module cpu_core_unit
  import cpu_core_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  mem_core_bus_request_if.master  mem_bus_request,
  mem_core_bus_response_if.slave  mem_bus_response,
  output logic                    offload
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] pc_next;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [6:0]  word_sel;

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wr_en;
  logic [XLEN-1:0] wr_data;

  assign mem_bus_request.valid = req_valid;
  assign mem_bus_request.addr  = req_addr;
  assign mem_bus_request.write = 1'b0;

  assign pc_next  = pc + 32'd4;
  assign word_sel = {pc[3:2], 5'b00000};

  cpu_reg_bank bank_reg (
    .clock    (clock),
    .reset    (reset),
    .rs1_addr (rs1_of(ir)),
    .rs2_addr (rs2_of(ir)),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (wr_en),
    .wr_addr  (rd_of(ir)),
    .wr_data  (wr_data)
  );

  // NOPs and unknown opcodes fall through with no write
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (op_of(ir))
      OP_LDI: begin wr_en = 1'b1; wr_data = {12'b0, imm_of(ir)}; end
      OP_ADD: begin wr_en = 1'b1; wr_data = rs1_data + rs2_data; end
      OP_SUB: begin wr_en = 1'b1; wr_data = rs1_data - rs2_data; end
      OP_MUL: begin wr_en = 1'b1; wr_data = rs1_data * rs2_data; end
      default: ;
    endcase
    if (state != EXEC) wr_en = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH_REQ;
      pc        <= BOOT_ADDR;
      ir        <= '0;
      req_valid <= 1'b0;
      req_addr  <= line_addr(BOOT_ADDR);
      offload   <= 1'b0;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (req_valid && mem_bus_request.ready) begin
            req_valid <= 1'b0;
            state     <= FETCH_WAIT;
          end else begin
            req_valid <= 1'b1;
            req_addr  <= line_addr(pc);
          end
        end
        FETCH_WAIT: begin
          if (mem_bus_response.valid) begin
            ir    <= mem_bus_response.data[word_sel +: 32];
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op_of(ir) == OP_STOP) begin
            offload <= 1'b1;
            state   <= HALT;
          end else begin
            // next request is raised here so a fetch costs only one FETCH_REQ cycle
            pc        <= pc_next;
            req_valid <= 1'b1;
            req_addr  <= line_addr(pc_next);
            state     <= FETCH_REQ;
          end
        end
        HALT: offload <= 1'b1;
        default: state <= FETCH_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_unit.sv
// Self-checking bench: line memory responder with stalls/delays and an instruction-level reference interpreter.
module tb_cpu_core_unit;
  import cpu_core_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic offload;

  mem_core_bus_request_if  req_if ();
  mem_core_bus_response_if rsp_if ();

  cpu_core_unit dut (
    .clock            (clock),
    .reset            (reset),
    .mem_bus_request  (req_if),
    .mem_bus_response (rsp_if),
    .offload          (offload)
  );

  always #10 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] imem [256];
  logic [31:0] exp_regs [32];
  logic [31:0] exp_addr [$];
  logic [31:0] hs_q [$];

  int stall_len = 0;
  int cur_stall = 0;
  bit rand_stall = 0;
  bit rand_rsp = 0;
  bit spurious = 0;
  int stall_cnt = 0;
  int rsp_wait = 0;
  int hs_cnt = 0;
  logic [31:0] rsp_addr = '0;
  logic [31:0] stall_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_ldi(input int rd, input logic [19:0] imm);
    return {OP_LDI, 5'(rd), 1'b0, imm};
  endfunction

  function automatic logic [31:0] i_r(input logic [5:0] op, input int rd, input int rs1, input int rs2);
    return {op, 5'(rd), 5'(rs1), 5'(rs2), 11'b0};
  endfunction

  function automatic logic [31:0] i_stop();
    return {OP_STOP, 26'b0};
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int idx;
    if (a < BOOT_ADDR) return 32'h0;
    idx = int'((a - BOOT_ADDR) >> 2);
    if (idx >= 256) return 32'h0;
    return imem[idx];
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = word_at({a[31:4], 4'b0} + 32'(4*k));
    return l;
  endfunction

  // Reference: walk the program word by word with plain modulo-2^32 arithmetic
  task automatic model_run();
    logic [31:0] pc;
    logic [31:0] w;
    logic [31:0] a, b;
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    exp_addr.delete();
    pc = BOOT_ADDR;
    for (int n = 0; n < 256; n++) begin
      exp_addr.push_back(pc & 32'hFFFF_FFF0);
      w = word_at(pc);
      a = exp_regs[w[20:16]];
      b = exp_regs[w[15:11]];
      if (w[31:26] == 6'h3F) break;
      case (w[31:26])
        6'h01: exp_regs[w[25:21]] = {12'h0, w[19:0]};
        6'h02: exp_regs[w[25:21]] = a + b;
        6'h03: exp_regs[w[25:21]] = a - b;
        6'h04: exp_regs[w[25:21]] = 32'((64'(a) * 64'(b)) % 64'h1_0000_0000);
        default: ;
      endcase
      pc = pc + 32'd4;
    end
  endtask

  task automatic load(input logic [31:0] p [$]);
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < p.size(); i++) imem[i] = p[i];
    model_run();
  endtask

  task automatic do_reset(input string tag);
    logic [31:0] orv;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    orv = 32'h0;
    for (int i = 0; i < 32; i++) orv = orv | dut.bank_reg.reg_file[i];
    chk({tag, "_rst_regs"}, orv, 32'h0);
    chk({tag, "_rst_offload"}, {31'b0, offload}, 32'h0);
    chk({tag, "_rst_valid"}, {31'b0, req_if.valid}, 32'h0);
    reset = 1'b0;
    hs_q.delete();
    hs_cnt = 0;
    stall_cnt = 0;
    cur_stall = stall_len;
  endtask

  task automatic run_to_halt(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (offload !== 1'b1 && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_halt_timeout"}, {31'b0, offload}, 32'h1);
  endtask

  task automatic check_result(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), dut.bank_reg.reg_file[i], exp_regs[i]);
    repeat (10) @(negedge clock);
    chk({tag, "_req_count"}, 32'(hs_q.size()), 32'(exp_addr.size()));
    for (int i = 0; i < hs_q.size() && i < exp_addr.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), hs_q[i], exp_addr[i]);
    chk({tag, "_halt_valid"}, {31'b0, req_if.valid}, 32'h0);
    chk({tag, "_offload_sticky"}, {31'b0, offload}, 32'h1);
  endtask

  // Memory responder: optional ready stalls, response delay, and stray response pulses
  always @(negedge clock) begin
    rsp_if.valid = 1'b0;
    rsp_if.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        rsp_if.valid = 1'b1;
        rsp_if.data  = line_of(rsp_addr);
      end
    end else if (spurious && $urandom_range(0, 3) == 0) begin
      rsp_if.valid = 1'b1;
    end
    if (req_if.valid === 1'b1) begin
      if (stall_cnt < cur_stall) begin
        if (stall_cnt == 0) stall_addr = req_if.addr;
        else chk("stall_addr_stable", req_if.addr, stall_addr);
        req_if.ready = 1'b0;
        stall_cnt++;
      end else begin
        if (cur_stall > 0) chk("stall_addr_stable", req_if.addr, stall_addr);
        req_if.ready = 1'b1;
        stall_cnt = 0;
        rsp_wait = 1 + (rand_rsp ? int'($urandom_range(0, 3)) : 0);
        rsp_addr = req_if.addr;
        hs_q.push_back(req_if.addr);
        hs_cnt++;
        cur_stall = rand_stall ? int'($urandom_range(0, 3)) : stall_len;
      end
    end else begin
      req_if.ready = 1'b0;
      stall_cnt = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p1 [$];
    logic [31:0] p [$];
    int cyc;
    int n;
    logic [5:0] ops [6];

    req_if.ready = 1'b0;
    rsp_if.valid = 1'b0;
    rsp_if.data  = '0;
    ops = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h00, 6'h15};

    p1 = '{i_ldi(0, 20'd5), i_ldi(1, 20'd4), i_ldi(2, 20'd0), i_ldi(3, 20'd1),
           i_r(OP_MUL, 4, 0, 1), i_r(OP_ADD, 4, 4, 1), i_stop()};

    // 1: basic program
    load(p1);
    do_reset("t1");
    run_to_halt("t1", 60, cyc);
    chk("t1_r4_const", dut.bank_reg.reg_file[4], 32'd24);
    check_result("t1");

    // 2: large immediate and add
    p = '{i_ldi(5, 20'hFFFFF), i_r(OP_ADD, 6, 5, 5), i_stop()};
    load(p);
    do_reset("t2");
    run_to_halt("t2", 60, cyc);
    chk("t2_r6_const", dut.bank_reg.reg_file[6], 32'h001F_FFFE);
    check_result("t2");

    // 3: multiply overflow and subtract underflow
    p = '{i_ldi(1, 20'h10000), i_ldi(2, 20'h10000), i_r(OP_MUL, 3, 1, 2), i_r(OP_SUB, 4, 0, 3),
          i_ldi(7, 20'd1), i_r(OP_SUB, 8, 0, 7), i_stop()};
    load(p);
    do_reset("t3");
    run_to_halt("t3", 60, cyc);
    chk("t3_r8_const", dut.bank_reg.reg_file[8], 32'hFFFF_FFFF);
    check_result("t3");

    // 4: five ready-low cycles on every request
    stall_len = 5;
    load(p1);
    do_reset("t4");
    run_to_halt("t4", 120, cyc);
    check_result("t4");
    stall_len = 0;

    // 5: reset lands in the third fetch's wait, together with its response
    load(p1);
    do_reset("t5a");
    n = 0;
    while (hs_cnt < 3 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("t5_reach_third_fetch", 32'(hs_cnt >= 3), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_mid_offload", {31'b0, offload}, 32'h0);
    chk("t5_mid_valid", {31'b0, req_if.valid}, 32'h0);
    chk("t5_mid_r0", dut.bank_reg.reg_file[0], 32'h0);
    chk("t5_mid_r1", dut.bank_reg.reg_file[1], 32'h0);
    reset = 1'b0;
    hs_q.delete();
    hs_cnt = 0;
    run_to_halt("t5", 60, cyc);
    if (hs_q.size() > 0) chk("t5_first_addr", hs_q[0], 32'h0000_1000);
    else chk("t5_first_addr_missing", 32'(hs_q.size()), 32'h1);
    check_result("t5");

    // 6: STOP as the very first word
    p = '{i_stop()};
    load(p);
    do_reset("t6");
    run_to_halt("t6", 60, cyc);
    chk("t6_halt_latency", 32'(cyc <= 4), 32'h1);
    check_result("t6");

    // randomized programs with random stalls, delays and stray responses
    rand_stall = 1;
    rand_rsp = 1;
    spurious = 1;
    for (int t = 0; t < 4; t++) begin
      p.delete();
      n = int'($urandom_range(6, 24));
      for (int i = 0; i < n; i++) begin
        logic [5:0] op;
        op = ops[$urandom_range(0, 5)];
        if (op == OP_LDI) p.push_back(i_ldi(int'($urandom_range(0, 7)), 20'($urandom())));
        else if (op == 6'h00) p.push_back(32'h0);
        else p.push_back(i_r(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
      end
      p.push_back(i_stop());
      load(p);
      do_reset($sformatf("rnd%0d", t));
      run_to_halt($sformatf("rnd%0d", t), 600, cyc);
      check_result($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
